instr_mem_responder: RTL and testbench

INSTR_MEM_RESPONDER -- requirements
Module: instr_mem_responder

---
 rtl/instr_mem_responder_pkg.sv | 34 +++
 rtl/instr_mem_responder_imem_array.sv | 24 ++
 rtl/instr_mem_responder.sv | 130 +++++++++++++
 tb/tb_instr_mem_responder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_responder_pkg.sv
// Shared CPU definitions for the instruction-memory responder: FSM states,
// fault codes, the NOP word and the address legality check.
package instr_mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'b00,
    FAULT_MISALIGN = 2'b01,
    FAULT_RANGE    = 2'b10
  } fault_t;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // Misalignment wins over out-of-range; used for both fetches and loads.
  function automatic fault_t addr_check(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input logic [31:0] depth);
    logic [31:0] off;
    fault_t      f;
    off = addr - base;
    f   = FAULT_NONE;
    if (addr[1:0] != 2'b00)
      f = FAULT_MISALIGN;
    else if ((addr < base) || ({2'b00, off[31:2]} >= depth))
      f = FAULT_RANGE;
    return f;
  endfunction

endpackage

// File: rtl/instr_mem_responder_imem_array.sv
// Instruction word storage: one synchronous write port, one combinational
// read port. Contents are not reset.
module imem_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = 8
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  logic [31:0]   wr_data,
  input  logic [AW-1:0] rd_idx,
  output logic [31:0]   rd_data
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_idx] <= wr_data;
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction fetch responder: address checks, wait-state timing and a
// valid/ready response handshake in front of a loadable word array.
//
// state   | meaning
// IDLE    | ready for a fetch or a program-load write
// WAIT    | counting wait states before a good response
// RESP    | response held until the consumer takes it
module instr_mem_responder
  import instr_mem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_instr,
  output logic [1:0]  rsp_fault,
  input  logic        rsp_ready,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic        busy
);

  localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [31:0] DEPTH_W   = 32'(DEPTH_WORDS);

  state_t          state;
  logic [3:0]      cnt;
  logic [AW-1:0]   idx_q;
  logic [AW-1:0]   req_idx;
  logic [AW-1:0]   load_idx;
  logic [AW-1:0]   rd_idx;
  logic [31:0]     rd_data;
  fault_t          req_fault;
  fault_t          load_fault;
  logic            accept;
  logic            wr_en;

  assign req_idx    = AW'((req_addr - BASE_ADDR) >> 2);
  assign load_idx   = AW'((load_addr - BASE_ADDR) >> 2);
  assign req_fault  = addr_check(req_addr, BASE_ADDR, DEPTH_W);
  assign load_fault = addr_check(load_addr, BASE_ADDR, DEPTH_W);

  assign req_ready = (state == ST_IDLE) && !load_en;
  assign accept    = reset && req_valid && req_ready;
  assign wr_en     = reset && load_en && (state == ST_IDLE) && (load_fault == FAULT_NONE);

  // The address of the word being fetched comes straight from the request
  // while idle, so a zero-wait fetch can capture data on the accept edge.
  assign rd_idx = (state == ST_IDLE) ? req_idx : idx_q;

  imem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_imem_array (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_idx  (load_idx),
    .wr_data (load_data),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      idx_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_instr <= NOP_WORD;
      rsp_fault <= FAULT_NONE;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            busy  <= 1'b1;
            idx_q <= req_idx;
            if (req_fault != FAULT_NONE) begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_instr <= NOP_WORD;
              rsp_fault <= req_fault;
            end else if (WAIT_STATES == 0) begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_instr <= rd_data;
              rsp_fault <= FAULT_NONE;
            end else begin
              state <= ST_WAIT;
              cnt   <= WAIT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_instr <= rd_data;
            rsp_fault <= FAULT_NONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            rsp_instr <= NOP_WORD;
            rsp_fault <= FAULT_NONE;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench for instr_mem_responder (DEPTH_WORDS=256, WAIT_STATES=1,
// BASE_ADDR=0) with hand-computed expected values.
module tb_instr_mem_responder;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_instr;
  logic [1:0]  rsp_fault;
  logic        rsp_ready;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;

  instr_mem_responder #(
    .DEPTH_WORDS (256),
    .WAIT_STATES (1),
    .BASE_ADDR   (32'h0000_0000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_instr (rsp_instr),
    .rsp_fault (rsp_fault),
    .rsp_ready (rsp_ready),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  // Issue a fetch, measure cycles from acceptance to rsp_valid, check the
  // response, then complete the handshake and confirm return to IDLE.
  task automatic fetch(input string tag, input logic [31:0] a, input int exp_lat,
                       input logic [31:0] exp_instr, input logic [1:0] exp_fault);
    int lat;
    req_valid = 1'b1;
    req_addr  = a;
    #1;
    chk({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".instr"}, rsp_instr, exp_instr);
    chk({tag, ".fault"}, 32'(rsp_fault), 32'(exp_fault));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, ".idle_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int seen;
    reset     = 1'b0;
    req_valid = 1'b1;
    req_addr  = 32'h0;
    rsp_ready = 1'b0;
    load_en   = 1'b1;
    load_addr = 32'h0;
    load_data = 32'hFFFF_FFFF;
    tick();
    tick();
    req_valid = 1'b0;
    load_en   = 1'b0;
    chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.rsp_instr", rsp_instr, 32'h0);
    chk("rst.rsp_fault", 32'(rsp_fault), 32'd0);
    reset = 1'b1;
    #1;
    chk("rst.req_ready", 32'(req_ready), 32'd1);

    do_load(32'h0, 32'h2008_0005);
    fetch("good0", 32'h0, 2, 32'h2008_0005, 2'b00);
    fetch("misal", 32'h2, 1, 32'h0, 2'b01);
    fetch("range", 32'h400, 1, 32'h0, 2'b10);
    fetch("misal_over_range", 32'h401, 1, 32'h0, 2'b01);
    do_load(32'h3FC, 32'hCAFE_BABE);
    fetch("last_word", 32'h3FC, 2, 32'hCAFE_BABE, 2'b00);

    // Back-pressure: outputs hold, no acceptance, loads ignored in RESP.
    req_valid = 1'b1;
    req_addr  = 32'h0;
    tick();
    req_valid = 1'b0;
    tick();
    chk("stall.enter", 32'(rsp_valid), 32'd1);
    req_valid = 1'b1;
    req_addr  = 32'h4;
    load_en   = 1'b1;
    load_addr = 32'h0;
    load_data = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall.valid", 32'(rsp_valid), 32'd1);
      chk("stall.instr", rsp_instr, 32'h2008_0005);
      chk("stall.fault", 32'(rsp_fault), 32'd0);
      chk("stall.req_ready", 32'(req_ready), 32'd0);
    end
    load_en   = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    chk("stall.done_busy", 32'(busy), 32'd0);
    chk("stall.done_valid", 32'(rsp_valid), 32'd0);
    #1;
    chk("stall.done_ready", 32'(req_ready), 32'd1);
    fetch("load_in_resp_ignored", 32'h0, 2, 32'h2008_0005, 2'b00);

    // Load and request together: load wins, request taken next cycle.
    load_en   = 1'b1;
    load_addr = 32'h10;
    load_data = 32'h1234_5678;
    req_valid = 1'b1;
    req_addr  = 32'h10;
    #1;
    chk("both.req_ready", 32'(req_ready), 32'd0);
    tick();
    load_en = 1'b0;
    chk("both.busy", 32'(busy), 32'd0);
    fetch("both.fetch", 32'h10, 2, 32'h1234_5678, 2'b00);

    // Illegal loads are dropped.
    do_load(32'h12, 32'h0BAD_0001);
    do_load(32'h400, 32'h0BAD_0002);
    fetch("drop_misal", 32'h10, 2, 32'h1234_5678, 2'b00);
    fetch("drop_range", 32'h0, 2, 32'h2008_0005, 2'b00);

    // Reset during WAIT abandons the fetch.
    req_valid = 1'b1;
    req_addr  = 32'h3FC;
    tick();
    req_valid = 1'b0;
    chk("rst_wait.busy_before", 32'(busy), 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("rst_wait.valid", 32'(rsp_valid), 32'd0);
    chk("rst_wait.busy", 32'(busy), 32'd0);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rsp_valid) seen++;
    end
    chk("rst_wait.no_rsp", 32'(seen), 32'd0);
    fetch("mem_kept", 32'h3FC, 2, 32'hCAFE_BABE, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
